// File: rtl/bsg_mesh_proc_traffic_gen.sv
// Traffic source for one mesh tile's proc input: one packet per destination per round, deterministic payload.
// First v_o one cycle after en_i; up to one packet per cycle; v_o/data_o hold while ready_and_i is low.
module bsg_mesh_proc_traffic_gen #(
    parameter  int x_cord_width_p = 2,
    parameter  int y_cord_width_p = 2,
    parameter  int data_width_p   = 4,
    parameter  int x_dim_p        = 4,
    parameter  int y_dim_p        = 4,
    parameter  int rounds_p       = 2,
    parameter  int gap_cycles_p   = 0,
    localparam int total_lp       = x_dim_p * y_dim_p * rounds_p,
    localparam int width_lp       = data_width_p + x_cord_width_p + y_cord_width_p,
    localparam int count_w_lp     = $clog2(total_lp + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    output logic [width_lp-1:0]       data_o,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic                      done_o,
    output logic [count_w_lp-1:0]     sent_count_o
);

    localparam int round_w_lp = (rounds_p > 1) ? $clog2(rounds_p) : 1;
    localparam int gap_w_lp   = (gap_cycles_p > 0) ? $clog2(gap_cycles_p + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

    state_e                    state_q, state_n;
    logic [x_cord_width_p-1:0] dest_x_q;
    logic [y_cord_width_p-1:0] dest_y_q;
    logic [round_w_lp-1:0]     round_q;
    logic [gap_w_lp-1:0]       gap_q, gap_n;
    logic [count_w_lp-1:0]     count_q;

    logic                      transfer;
    logic                      last_pkt;
    logic                      x_wrap, y_wrap, round_wrap;
    int                        my_id, dest_id;
    logic [data_width_p-1:0]   payload;

    // Reset masks v_o combinationally so nothing can transfer in a reset cycle.
    assign v_o        = (state_q == SEND) && !reset;
    assign transfer   = v_o && ready_and_i;
    assign last_pkt   = (count_q == count_w_lp'(total_lp - 1));
    assign x_wrap     = (dest_x_q == x_cord_width_p'(x_dim_p - 1));
    assign y_wrap     = (dest_y_q == y_cord_width_p'(y_dim_p - 1));
    assign round_wrap = (round_q == round_w_lp'(rounds_p - 1));

    always_comb begin
        my_id   = int'(my_y_i) * x_dim_p + int'(my_x_i);
        dest_id = int'(dest_y_q) * x_dim_p + int'(dest_x_q);
        payload = data_width_p'(my_id) ^ data_width_p'(dest_id) ^ data_width_p'(round_q);
    end

    assign data_o       = v_o ? {payload, dest_x_q, dest_y_q} : '0;
    assign done_o       = (state_q == DONE);
    assign sent_count_o = count_q;

    always_comb begin
        state_n = state_q;
        gap_n   = gap_q;
        case (state_q)
            IDLE: begin
                if (en_i) state_n = SEND;
            end
            SEND: begin
                if (transfer) begin
                    if (last_pkt) begin
                        state_n = DONE;
                    end else if (gap_cycles_p > 0) begin
                        state_n = GAP;
                        gap_n   = gap_w_lp'(gap_cycles_p);
                    end else if (!en_i) begin
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                gap_n = gap_q - 1'b1;
                if (gap_q <= gap_w_lp'(1)) state_n = en_i ? SEND : IDLE;
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dest_x_q <= '0;
            dest_y_q <= '0;
            round_q  <= '0;
            gap_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_n;
            gap_q   <= gap_n;
            if (transfer) begin
                if (count_q != count_w_lp'(total_lp)) count_q <= count_q + 1'b1;
                // x is the fastest-moving index, round the slowest
                if (x_wrap) begin
                    dest_x_q <= '0;
                    if (y_wrap) begin
                        dest_y_q <= '0;
                        round_q  <= round_wrap ? '0 : round_q + 1'b1;
                    end else begin
                        dest_y_q <= dest_y_q + 1'b1;
                    end
                end else begin
                    dest_x_q <= dest_x_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_mesh_proc_traffic_gen.sv
// Directed bench: default-parameter generator, a gap_cycles_p=3 copy and a 1x1x1 copy.
module tb_bsg_mesh_proc_traffic_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       en0 = 1'b0, rdy0 = 1'b0, v0, done0;
    logic [7:0] data0;
    logic [5:0] cnt0;
    logic       en1 = 1'b0, rdy1 = 1'b0, v1, done1;
    logic [7:0] data1;
    logic [5:0] cnt1;
    logic       en2 = 1'b0, rdy2 = 1'b0, v2, done2;
    logic [7:0] data2;
    logic [0:0] cnt2;

    bsg_mesh_proc_traffic_gen dut0 (
        .clk(clk), .reset(reset), .en_i(en0), .my_x_i(2'd1), .my_y_i(2'd2),
        .data_o(data0), .v_o(v0), .ready_and_i(rdy0), .done_o(done0), .sent_count_o(cnt0));

    bsg_mesh_proc_traffic_gen #(.gap_cycles_p(3)) dut1 (
        .clk(clk), .reset(reset), .en_i(en1), .my_x_i(2'd1), .my_y_i(2'd2),
        .data_o(data1), .v_o(v1), .ready_and_i(rdy1), .done_o(done1), .sent_count_o(cnt1));

    bsg_mesh_proc_traffic_gen #(.x_dim_p(1), .y_dim_p(1), .rounds_p(1)) dut2 (
        .clk(clk), .reset(reset), .en_i(en2), .my_x_i(2'd0), .my_y_i(2'd0),
        .data_o(data2), .v_o(v2), .ready_and_i(rdy2), .done_o(done2), .sent_count_o(cnt2));

    int         cyc = 0;
    logic [7:0] got0[$], got1[$], got2[$];
    int         st0[$], st1[$];
    int         stab_err = 0;
    logic       pv = 1'b0, prdy = 1'b0;
    logic [7:0] pdata = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && v0 && rdy0) begin got0.push_back(data0); st0.push_back(cyc); end
        if (!reset && v1 && rdy1) begin got1.push_back(data1); st1.push_back(cyc); end
        if (!reset && v2 && rdy2) got2.push_back(data2);
        if (!reset && pv && !prdy && (!v0 || data0 != pdata)) stab_err <= stab_err + 1;
        pv    <= v0 && !reset;
        prdy  <= rdy0;
        pdata <= data0;
    end

    int pass = 0, total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected packet k for a tile whose id is mid.
    function automatic logic [7:0] exp_pkt(input int k, input int xd, input int yd, input int mid);
        int n, r, id, x, y, p;
        n  = xd * yd;
        r  = k / n;
        id = k % n;
        x  = id % xd;
        y  = id / xd;
        p  = (mid ^ id ^ r) & 15;
        return {p[3:0], x[1:0], y[1:0]};
    endfunction

    task automatic chk_seq(input string nm, input logic [7:0] q[$], input int b, input int n);
        int err, first;
        err = 0; first = -1;
        chk({nm, "_count"}, q.size() - b, n);
        for (int k = 0; k < n && b + k < q.size(); k++)
            if (q[b+k] != exp_pkt(k, 4, 4, 9)) begin
                err++;
                if (first < 0) first = k;
            end
        chk({nm, "_order_errs(first idx)"}, err == 0 ? 0 : first, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; en0 = 1'b0; rdy0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run0(input bit rnd, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done0) begin dcyc = cyc; break; end
            rdy0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("run_done_within_budget", int'(done0), 1);
    endtask

    typedef struct {
        int         idx;
        logic [1:0] x;
        logic [1:0] y;
        logic [3:0] pay;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   b, dcyc, perr, late;
        tbl[0] = '{0,  2'd0, 2'd0, 4'h9};
        tbl[1] = '{1,  2'd1, 2'd0, 4'h8};
        tbl[2] = '{5,  2'd1, 2'd1, 4'hC};
        tbl[3] = '{15, 2'd3, 2'd3, 4'h6};
        tbl[4] = '{16, 2'd0, 2'd0, 4'h8};
        tbl[5] = '{31, 2'd3, 2'd3, 4'h7};

        // reset state
        @(negedge clk);
        chk("reset_v", int'(v0), 0);
        chk("reset_data", int'(data0), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_cnt", int'(cnt0), 0);
        chk("reset_done", int'(done0), 0);
        chk("idle_v_en_low", int'(v0), 0);

        // back-to-back with ready held high
        b = got0.size();
        en0 = 1'b1; rdy0 = 1'b1;
        @(negedge clk);
        chk("first_v_latency", int'(v0), 1);
        chk("first_data", int'(data0), 8'h90);
        run0(1'b0, 200, dcyc);
        chk_seq("t1", got0, b, 32);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1_vec%0d", tbl[i].idx),
                (b + tbl[i].idx < got0.size()) ? int'(got0[b+tbl[i].idx]) : -1,
                int'({tbl[i].pay, tbl[i].x, tbl[i].y}));
        chk("t1_back_to_back_span", st0.size() >= b + 32 ? st0[b+31] - st0[b] : -1, 31);
        chk("t1_done_cycle_after_last", st0.size() > 0 ? dcyc - st0[st0.size()-1] : -1, 1);
        chk("t1_sent_count", int'(cnt0), 32);
        repeat (3) @(negedge clk);
        chk("t1_done_v_low", int'(v0), 0);
        chk("t1_no_extra", got0.size() - b, 32);
        chk("t1_sent_count_saturated", int'(cnt0), 32);

        // random backpressure
        do_reset();
        b = got0.size();
        en0 = 1'b1;
        run0(1'b1, 1000, dcyc);
        chk_seq("t2", got0, b, 32);
        chk("t2_stability_errs", stab_err, 0);

        // pause after the 5th transfer
        do_reset();
        b = got0.size();
        en0 = 1'b1; rdy0 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (got0.size() - b >= 4) break;
        end
        en0 = 1'b0;
        perr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (v0) perr++;
        end
        chk("t4_pause_v_high_cycles", perr, 0);
        chk("t4_count_at_pause", got0.size() - b, 5);
        chk("t4_sent_count_at_pause", int'(cnt0), 5);
        en0 = 1'b1;
        run0(1'b0, 200, dcyc);
        chk_seq("t4", got0, b, 32);
        chk("t4_resume_pkt", (b + 5 < got0.size()) ? int'(got0[b+5]) : -1, 8'hC5);

        // reset mid-run after 20 transfers
        do_reset();
        b = got0.size();
        en0 = 1'b1; rdy0 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (got0.size() - b >= 20) break;
        end
        reset = 1'b1; en0 = 1'b0;
        @(negedge clk);
        chk("t5_reset_v", int'(v0), 0);
        chk("t5_reset_data", int'(data0), 0);
        chk("t5_no_xfer_in_reset", got0.size() - b, 20);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_cnt_cleared", int'(cnt0), 0);
        chk("t5_done_cleared", int'(done0), 0);
        b = got0.size();
        en0 = 1'b1;
        run0(1'b0, 200, dcyc);
        chk_seq("t5", got0, b, 32);

        // gap_cycles_p = 3
        en1 = 1'b1; rdy1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done1) break;
        end
        chk("t3_done", int'(done1), 1);
        chk_seq("t3", got1, 0, 32);
        chk("t3_span", st1.size() >= 32 ? st1[31] - st1[0] : -1, 124);
        perr = 0;
        for (int i = 1; i < st1.size(); i++)
            if (st1[i] - st1[i-1] != 4) perr++;
        chk("t3_spacing_errs", perr, 0);
        chk("t3_sent_count", int'(cnt1), 32);

        // 1x1 mesh, one round
        en2 = 1'b1; rdy2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done2) break;
        end
        chk("t6_done", int'(done2), 1);
        late = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (v2) late++;
        end
        chk("t6_v_after_done", late, 0);
        chk("t6_pkt_count", got2.size(), 1);
        chk("t6_pkt_data", got2.size() > 0 ? int'(got2[0]) : -1, 0);
        chk("t6_sent_count", int'(cnt2), 1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
